// File: rtl/uart_word_deframer_if.sv
// Word stream from the deframer FIFO to its consumer.
// The master presents word_out/word_valid and the slave answers with word_ready.
interface uart_word_deframer_if;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/uart_word_deframer.sv
// Parses SYNC/LEN/(LO,HI)xLEN/CHK packets from a UART byte stream into 16-bit words.
// Completed words go into a small first-word-fall-through FIFO. Each frame ends with one ok/err pulse.
module uart_word_deframer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned MAX_WORDS      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_done,
  uart_word_deframer_if.master wout,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]    MAX_LEN  = 8'(MAX_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_LO, S_HI, S_CHK} state_t;

  state_t        state_q, state_d;
  logic          rx_done_q;
  logic          byte_stb;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    lo_q, lo_d;
  logic          ovf_q, ovf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_req, push_ok, pop, full;

  assign byte_stb = rx_done & ~rx_done_q;
  assign pop      = (count_q != '0) && wout.word_ready;
  assign full     = (count_q == FULL_CNT);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    state_d     = state_q;
    csum_d      = csum_q;
    rem_d       = rem_q;
    lo_d        = lo_q;
    ovf_d       = ovf_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
    tmo_d       = (state_q == S_IDLE || byte_stb) ? '0 : tmo_q + 1'b1;

    if (byte_stb) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_LEN;
            ovf_d   = 1'b0;
          end
        end
        S_LEN: begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            rem_d   = rx_data;
            csum_d  = rx_data;
            state_d = S_LO;
          end
        end
        S_LO: begin
          lo_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = S_HI;
        end
        S_HI: begin
          push_req = 1'b1;
          if (full && !pop) ovf_d = 1'b1;
          csum_d  = csum_q ^ rx_data;
          rem_d   = rem_q - 8'd1;
          state_d = (rem_q == 8'd1) ? S_CHK : S_LO;
        end
        S_CHK: begin
          if (rx_data == csum_q && !ovf_q) frame_ok_d  = 1'b1;
          else                             frame_err_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rx_done_q   <= 1'b0;
      csum_q      <= '0;
      rem_q       <= '0;
      lo_q        <= '0;
      ovf_q       <= 1'b0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rx_done_q   <= rx_done;
      csum_q      <= csum_d;
      rem_q       <= rem_d;
      lo_q        <= lo_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= {rx_data, lo_q};
  end

  // Storage is not reset, so the head word is masked to zero while the FIFO is empty.
  assign wout.word_valid = (count_q != '0);
  assign wout.word_out   = (count_q != '0) ? mem_q[rd_ptr_q] : 16'h0000;
  assign frame_ok        = frame_ok_q;
  assign frame_err       = frame_err_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_word_deframer.sv
// Directed bench for uart_word_deframer: frames, bad checksum/length, overflow,
// timeout, mid-frame reset and level-style rx_done.
module tb_uart_word_deframer;
  localparam int TMO = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       frame_ok, frame_err, busy;

  uart_word_deframer_if wif ();

  uart_word_deframer #(
    .FIFO_DEPTH(4), .MAX_WORDS(64), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hAA)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .wout(wif), .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  bit both_seen = 1'b0;
  logic [15:0] got[$];

  // Observe pulses and accepted words half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
      if (frame_ok && frame_err) both_seen = 1'b1;
      if (wif.word_valid && wif.word_ready) begin
        got.push_back(wif.word_out);
        $display("[TB] word accepted 0x%04h", wif.word_out);
      end
    end
  end

  task automatic clear_obs();
    ok_cnt = 0;
    err_cnt = 0;
    got.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_level_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_done = 1'b0;
    wif.word_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (wif.word_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", wif.word_valid); end
    tests_run++;
    if (wif.word_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_word got %04h want 0000", wif.word_out); end
    tests_run++;
    if ({busy, frame_ok, frame_err} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %03b want 000", {busy, frame_ok, frame_err}); end
    rst = 1'b0;
    @(posedge clk); #1;
    clear_obs();
  endtask

  task automatic test_good_frame();
    logic [7:0]  bytes [7] = '{8'hAA, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h42};
    logic [15:0] exp [2] = '{16'h1234, 16'hABCD};
    clear_obs();
    wif.word_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_byte(bytes[i]);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (got.size() !== 2) begin tests_failed++; $display("FAIL good_count got %0d want 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL good_word%0d got %04h want %04h", i, got[i], exp[i]); end
    end
    tests_run++;
    if (ok_cnt !== 1 || err_cnt !== 0) begin tests_failed++; $display("FAIL good_pulses got ok=%0d err=%0d want ok=1 err=0", ok_cnt, err_cnt); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL good_busy got %0b want 0", busy); end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] bytes [7] = '{8'hAA, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h43};
    clear_obs();
    wif.word_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_byte(bytes[i]);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (got.size() !== 2 || got[0] !== 16'h1234 || got[1] !== 16'hABCD) begin
      tests_failed++; $display("FAIL badchk_words got n=%0d want 1234,ABCD", got.size());
    end
    tests_run++;
    if (ok_cnt !== 0 || err_cnt !== 1) begin tests_failed++; $display("FAIL badchk_pulses got ok=%0d err=%0d want ok=0 err=1", ok_cnt, err_cnt); end
  endtask

  task automatic test_bad_length();
    logic [7:0] bytes [4] = '{8'h55, 8'h13, 8'hAA, 8'h00};
    clear_obs();
    for (int i = 0; i < 4; i++) send_byte(bytes[i]);
    tests_run++;
    if (err_cnt !== 1 || busy !== 1'b0) begin tests_failed++; $display("FAIL len0 got err=%0d busy=%0b want err=1 busy=0", err_cnt, busy); end
    send_byte(8'hAA);
    send_byte(8'h41);
    tests_run++;
    if (err_cnt !== 2 || ok_cnt !== 0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL len65 got err=%0d ok=%0d busy=%0b want err=2 ok=0 busy=0", err_cnt, ok_cnt, busy);
    end
    tests_run++;
    if (got.size() !== 0) begin tests_failed++; $display("FAIL badlen_words got %0d want 0", got.size()); end
  endtask

  task automatic test_overflow();
    logic [7:0]  bytes [13] = '{8'hAA, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0E};
    logic [15:0] exp [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    clear_obs();
    wif.word_ready = 1'b0;
    for (int i = 0; i < 13; i++) send_byte(bytes[i]);
    tests_run++;
    if (err_cnt !== 1 || ok_cnt !== 0) begin tests_failed++; $display("FAIL ovf_pulses got ok=%0d err=%0d want ok=0 err=1", ok_cnt, err_cnt); end
    tests_run++;
    if (wif.word_valid !== 1'b1 || wif.word_out !== 16'h0201) begin
      tests_failed++; $display("FAIL ovf_head got v=%0b w=%04h want v=1 w=0201", wif.word_valid, wif.word_out);
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (wif.word_out !== 16'h0201) begin tests_failed++; $display("FAIL ovf_hold got %04h want 0201", wif.word_out); end
    wif.word_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    tests_run++;
    if (got.size() !== 4) begin tests_failed++; $display("FAIL ovf_count got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      tests_run++;
      if (got[i] !== exp[i]) begin tests_failed++; $display("FAIL ovf_word%0d got %04h want %04h", i, got[i], exp[i]); end
    end
    tests_run++;
    if (wif.word_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_empty got %0b want 0", wif.word_valid); end
  endtask

  task automatic test_timeout();
    int n;
    clear_obs();
    wif.word_ready = 1'b1;
    send_byte(8'hAA);
    send_byte(8'h03);
    send_byte(8'h34);
    rx_data = 8'h12;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    n = -1;
    for (int k = 1; k <= TMO + 10; k++) begin
      @(posedge clk); #1;
      if (frame_err) begin
        n = k;
        break;
      end
    end
    tests_run++;
    if (n !== TMO) begin tests_failed++; $display("FAIL timeout_delay got %0d want %0d", n, TMO); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_busy got %0b want 0", busy); end
    @(posedge clk); #1;
    tests_run++;
    if (err_cnt !== 1 || got.size() !== 1) begin
      tests_failed++; $display("FAIL timeout_once got err=%0d words=%0d want err=1 words=1", err_cnt, got.size());
    end
    clear_obs();
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h67);
    tests_run++;
    if (ok_cnt !== 1 || err_cnt !== 0) begin tests_failed++; $display("FAIL after_timeout got ok=%0d err=%0d want ok=1 err=0", ok_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_obs();
    wif.word_ready = 1'b0;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (wif.word_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_state got v=%0b busy=%0b want 0 0", wif.word_valid, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ok_cnt !== 0 || err_cnt !== 0) begin tests_failed++; $display("FAIL midrst_pulse got ok=%0d err=%0d want 0 0", ok_cnt, err_cnt); end
    wif.word_ready = 1'b1;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h67);
    tests_run++;
    if (ok_cnt !== 1 || got.size() !== 1 || got[0] !== 16'hABCD) begin
      tests_failed++; $display("FAIL midrst_after got ok=%0d words=%0d want ok=1 one ABCD", ok_cnt, got.size());
    end
  endtask

  task automatic test_level_rx_done();
    logic [7:0] bytes [7] = '{8'hAA, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h42};
    clear_obs();
    wif.word_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_level_byte(bytes[i]);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (got.size() !== 2 || got[0] !== 16'h1234 || got[1] !== 16'hABCD) begin
      tests_failed++; $display("FAIL level_words got n=%0d want 1234,ABCD", got.size());
    end
    tests_run++;
    if (ok_cnt !== 1 || err_cnt !== 0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL level_pulses got ok=%0d err=%0d busy=%0b want 1 0 0", ok_cnt, err_cnt, busy);
    end
  endtask

  initial begin
    wif.word_ready = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_overflow();
    test_timeout();
    test_reset_mid_frame();
    test_level_rx_done();
    tests_run++;
    if (both_seen !== 1'b0) begin tests_failed++; $display("FAIL pulse_exclusive got %0b want 0", both_seen); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/uart_word_deframer.md
Name: uart_word_deframer

Overview:
- Sits directly downstream of the UART receiver. It consumes the receiver's byte stream (`data_out`/`done`) and parses framed packets.
- Each packet carries 16-bit little-endian words, e.g. fixed-point weights and inputs for the neural-network core.
- Completed words are buffered in a small FIFO and presented on a valid/ready interface.
- Frame-level status (good/bad) is reported per packet.

Parameters:
- FIFO_DEPTH, 4: word FIFO entries; must be a power of 2, ≥2.
- MAX_WORDS, 64: largest legal payload length in words (1..255).
- TIMEOUT_CYCLES, 2048: idle clocks allowed between bytes inside a frame. A byte at 32 clk/bit takes 320 clk.
- SYNC_BYTE, 8'hAA: frame start marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from UART receiver; valid when rx_done rises.
- rx_done  in  1  receiver byte-complete flag; only its rising edge is used, so a level or a pulse both work.
- word_out  out  16  FIFO head word.
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  consumer accepts word_out on a clk edge where word_valid && word_ready.
- frame_ok  out  1  1-cycle pulse: frame finished with a correct checksum and no overflow.
- frame_err  out  1  1-cycle pulse: frame aborted or failed.
- busy  out  1  high whenever the parser state is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; FIFO emptied; word_valid=0; word_out=0.
  - frame_ok=0; frame_err=0; busy=0.
  - Checksum, counters and the rx_done edge register are cleared.
  - Reset mid-frame discards everything, including words already queued.
- Byte strobe:
  - byte_stb = rx_done & ~rx_done_q, where rx_done_q is registered.
  - rx_data is sampled on the same cycle as byte_stb. Strobe-to-state latency is 1 clk.
- Frame format: SYNC, LEN (word count), then LEN×(LO, HI), then CHK.
  - CHK = XOR of LEN and every payload byte.
- State machine (advances only on byte_stb unless noted):
  - IDLE: byte==SYNC_BYTE goes to LEN; any other byte is ignored and stays in IDLE.
  - LEN:
    - byte==0 or byte>MAX_WORDS: frame_err, go to IDLE.
    - Otherwise store count, csum=byte, go to LO.
  - LO: latch low byte, csum^=byte, go to HI.
  - HI:
    - Push {byte, lo} into the FIFO; csum^=byte; decrement the remaining count.
    - Go to CHK when remaining hits 0, else go to LO.
  - CHK:
    - byte==csum and no overflow flag: frame_ok.
    - Otherwise: frame_err.
    - Go to IDLE in either case.
- Timeout:
  - In any state other than IDLE, a counter increments each clk and clears on byte_stb.
  - When it reaches TIMEOUT_CYCLES-1: frame_err, go to IDLE.
- Overflow:
  - A push while the FIFO is full drops the word and sets a sticky per-frame overflow flag.
  - Parsing continues; the frame ends with frame_err at CHK. The flag clears on entering LEN.
  - A push and a pop on the same cycle while full is not overflow: the pop frees a slot and the push succeeds.
- FIFO:
  - Write latency: word visible on word_out 1 clk after the HI strobe.
  - First-word fall-through: word_out always shows the head entry.
  - Pointers wrap modulo FIFO_DEPTH. Use an explicit count or an extra pointer bit to distinguish full from empty.
  - word_out holds its value while word_valid && !word_ready.
  - A pop when empty is ignored.
- Bad frames: words already pushed are not retracted. The consumer discards on frame_err.
- Simultaneous events: timeout and byte_stb on the same cycle means byte_stb wins and the counter clears.
- Pulse rule: frame_ok and frame_err are never high together; each lasts exactly 1 clk.

Test Plan:
- Reset, then feed bytes AA 02 34 12 CD AB with CHK = 02^34^12^CD^AB = 0x42, ready held at 1 → words 0x1234 then 0xABCD appear; one frame_ok pulse; busy returns to 0.
- Same frame with CHK=0x43 → both words still delivered; frame_err pulses once, frame_ok never fires.
- Bytes 55 13 AA 00 → 55 and 13 ignored; the LEN=0 after AA causes frame_err; state back to IDLE. A following AA 41 (65 > MAX_WORDS) also gives frame_err.
- FIFO_DEPTH=4, word_ready=0, frame of LEN=5 with a valid CHK:
  - Expect 4 words held, 5th dropped, frame_err.
  - Then raise ready: exactly 4 words drain in order, then word_valid=0.
- Send AA 03 34 12, then go silent → frame_err exactly TIMEOUT_CYCLES clk after the last strobe; busy falls. A new valid frame afterwards gives frame_ok.
- Assert rst for 1 clk between the LO and HI bytes of the second word → FIFO empty, busy=0, no pulse. A subsequent clean frame parses correctly.
- Drive rx_done as a held level for 10 clk per byte → each byte is counted exactly once.
